// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: port IDs and the held command.
package sdram_arb_pkg;

  localparam int ARB_ADDR_W = 24;
  localparam int ARB_DATA_W = 16;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   address;
    logic [ARB_DATA_W-1:0]   writedata;
    logic [ARB_DATA_W/8-1:0] byteenable;
    logic                    is_write;
    port_id_t                port;
  } cmd_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Memory-mapped command/response bundle, used for both requester ports and the SDRAM side.
// Handshake: a command (read or write high) is accepted in any cycle where waitrequest is
// low; the master holds all command fields stable until then. Read data returns later, in
// order, one word per cycle with readdatavalid high.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_arb_id_fifo.sv
// Port-ID FIFO tracking which requester owns each outstanding read; head is combinational.
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  port_id_t      push_id,
  input  logic          pop,
  output port_id_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  port_id_t      mem_q [DEPTH];
  port_id_t      mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging an instruction-fetch port and a data port onto one SDRAM
// controller port, with in-order read-response routing by a port-ID FIFO.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int RD_DEPTH = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  sdram_port_arbiter_if.slave  p0,
  sdram_port_arbiter_if.slave  p1,
  sdram_port_arbiter_if.master m
);

  localparam int CW = $clog2(RD_DEPTH) + 1;

  cmd_t          cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  port_id_t      last_port_q, last_port_d;
  logic          err_q, err_d;
  logic          rst_done_q, rst_done_d;

  logic          drain, can_cap, rd_ok, elig0, elig1, cap;
  port_id_t      gnt;
  logic          sel_write;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  port_id_t      fifo_head;
  logic [CW-1:0] rd_count;

  // rd_count is sampled before this cycle's pop, so a full FIFO never pushes on a pop.
  assign rd_ok   = (rd_count < CW'(RD_DEPTH));
  assign elig0   = p0.write | (p0.read & rd_ok);
  assign elig1   = p1.write | (p1.read & rd_ok);
  assign drain   = cmd_valid_q & ~m.waitrequest;
  assign can_cap = ~cmd_valid_q | drain;
  assign gnt     = (elig0 & elig1) ? ~last_port_q : port_id_t'(~elig0);
  assign cap     = rst_done_q & can_cap & (elig0 | elig1);
  assign sel_write = gnt[0] ? p1.write : p0.write;

  assign fifo_push = cap & ~sel_write & ~fifo_full;
  assign fifo_pop  = m.readdatavalid & ~fifo_empty;

  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q & ~drain;
    last_port_d = last_port_q;
    err_d       = err_q | (m.readdatavalid & fifo_empty);
    rst_done_d  = 1'b1;
    if (cap) begin
      cmd_valid_d      = 1'b1;
      last_port_d      = gnt;
      cmd_d.port       = gnt;
      cmd_d.is_write   = sel_write;
      cmd_d.address    = ARB_ADDR_W'(gnt[0] ? p1.address : p0.address);
      cmd_d.writedata  = ARB_DATA_W'(gnt[0] ? p1.writedata : p0.writedata);
      cmd_d.byteenable = (ARB_DATA_W/8)'(gnt[0] ? p1.byteenable : p0.byteenable);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      last_port_q <= 1'b1;
      err_q       <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      last_port_q <= last_port_d;
      err_q       <= err_d;
      rst_done_q  <= rst_done_d;
    end
  end

  sdram_arb_id_fifo #(.DEPTH(RD_DEPTH)) u_id_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (fifo_push),
    .push_id (gnt),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rd_count)
  );

  assign m.address    = ADDR_W'(cmd_q.address);
  assign m.writedata  = DATA_W'(cmd_q.writedata);
  assign m.byteenable = (DATA_W/8)'(cmd_q.byteenable);
  assign m.read       = cmd_valid_q & ~cmd_q.is_write;
  assign m.write      = cmd_valid_q & cmd_q.is_write;

  assign p0.waitrequest   = ~(cap & (gnt == 1'b0));
  assign p1.waitrequest   = ~(cap & (gnt == 1'b1));
  assign p0.readdata      = m.readdata;
  assign p1.readdata      = m.readdata;
  assign p0.readdatavalid = fifo_pop & (fifo_head == 1'b0);
  assign p1.readdatavalid = fifo_pop & (fifo_head == 1'b1);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of grants, outstanding reads and response routing.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();
  sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(DEPTH)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .p0            (p0_if),
    .p1            (p1_if),
    .m             (m_if)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          mdl_valid;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wd;
  logic [1:0]    mdl_be;
  logic          mdl_isw;
  logic          mdl_last;
  logic          mdl_err;
  logic          mdl_armed;
  int            idq[$];
  int            grant_log[$];
  logic          cap_seen;
  logic          cap_port;

  task automatic model_reset();
    mdl_valid = 1'b0; mdl_addr = '0; mdl_wd = '0; mdl_be = '0; mdl_isw = 1'b0;
    mdl_last = 1'b1; mdl_err = 1'b0; mdl_armed = 1'b0;
    idq.delete();
    cap_seen = 1'b0; cap_port = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int port, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [1:0] be);
    if (port == 0) begin
      p0_if.read = rd; p0_if.write = wr; p0_if.address = a;
      p0_if.writedata = wd; p0_if.byteenable = be;
    end else begin
      p1_if.read = rd; p1_if.write = wr; p1_if.address = a;
      p1_if.writedata = wd; p1_if.byteenable = be;
    end
  endtask

  task automatic idle_ports();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: called at a falling edge with inputs set; checks, advances, returns at next falling edge.
  task automatic step();
    logic e0, e1, can, cap, g, s_rdv, s_wait, er0, er1;
    logic [AW-1:0] s_a; logic [DW-1:0] s_wd; logic [1:0] s_be; logic s_w;
    int head;
    #1;
    e0 = p0_if.write | (p0_if.read & (idq.size() < DEPTH));
    e1 = p1_if.write | (p1_if.read & (idq.size() < DEPTH));
    s_wait = m_if.waitrequest;
    s_rdv  = m_if.readdatavalid;
    can = !mdl_valid || !s_wait;
    cap = mdl_armed && can && (e0 || e1);
    g   = (e0 && e1) ? !mdl_last : !e0;
    chk("p0_waitrequest", p0_if.waitrequest, !(cap && !g));
    chk("p1_waitrequest", p1_if.waitrequest, !(cap && g));
    chk("m_read", m_if.read, mdl_valid && !mdl_isw);
    chk("m_write", m_if.write, mdl_valid && mdl_isw);
    if (mdl_valid) begin
      chk("m_address", m_if.address, mdl_addr);
      if (mdl_isw) begin
        chk("m_writedata", m_if.writedata, mdl_wd);
        chk("m_byteenable", m_if.byteenable, mdl_be);
      end
    end
    head = -1;
    if (idq.size() > 0) head = idq[0];
    er0 = s_rdv && (head == 0);
    er1 = s_rdv && (head == 1);
    chk("p0_readdatavalid", p0_if.readdatavalid, er0);
    chk("p1_readdatavalid", p1_if.readdatavalid, er1);
    if (s_rdv) begin
      chk("p0_readdata", p0_if.readdata, m_if.readdata);
      chk("p1_readdata", p1_if.readdata, m_if.readdata);
    end
    chk("err_flag", dut.err_q, mdl_err);
    if (g) begin s_a = p1_if.address; s_wd = p1_if.writedata; s_be = p1_if.byteenable; s_w = p1_if.write; end
    else   begin s_a = p0_if.address; s_wd = p0_if.writedata; s_be = p0_if.byteenable; s_w = p0_if.write; end
    @(posedge clk);
    if (s_rdv) begin
      if (idq.size() > 0) void'(idq.pop_front());
      else mdl_err = 1'b1;
    end
    if (cap) begin
      mdl_last = g; mdl_valid = 1'b1; mdl_addr = s_a; mdl_wd = s_wd; mdl_be = s_be; mdl_isw = s_w;
      if (!s_w) idq.push_back(int'(g));
      grant_log.push_back(int'(g));
    end else if (mdl_valid && !s_wait) begin
      mdl_valid = 1'b0;
    end
    cap_seen  = cap;
    cap_port  = g;
    mdl_armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_m_read"}, m_if.read, 1'b0);
    chk({tag, "_m_write"}, m_if.write, 1'b0);
    chk({tag, "_m_address"}, m_if.address, '0);
    chk({tag, "_m_writedata"}, m_if.writedata, '0);
    chk({tag, "_m_byteenable"}, m_if.byteenable, '0);
    chk({tag, "_p0_waitrequest"}, p0_if.waitrequest, 1'b1);
    chk({tag, "_p1_waitrequest"}, p1_if.waitrequest, 1'b1);
    chk({tag, "_p0_readdatavalid"}, p0_if.readdatavalid, 1'b0);
    chk({tag, "_p1_readdatavalid"}, p1_if.readdatavalid, 1'b0);
    chk({tag, "_err_flag"}, dut.err_q, 1'b0);
    @(negedge clk);
  endtask

  task automatic drain_reads();
    int guard;
    guard = 0;
    m_if.waitrequest = 1'b0;
    while (idq.size() > 0 && guard < 64) begin
      m_if.readdatavalid = 1'b1;
      m_if.readdata = DW'($urandom);
      step();
      guard++;
    end
    m_if.readdatavalid = 1'b0;
    chk("drain_reads_budget", guard < 64, 1'b1);
    step();
  endtask

  // ---------------- scoreboard / scenarios ----------------
  logic [DW-1:0] exp_q[$];

  initial begin
    int acc, same, c0, c1, guard;
    int route_port[4];
    logic [DW-1:0] route_data[4];
    route_port = '{0, 1, 1, 0};
    route_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst_n = 1'b0;
    idle_ports();
    m_if.waitrequest = 1'b0; m_if.readdata = '0; m_if.readdatavalid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // contention right after reset release; first cycle must not grant
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 24'h000010, '0, '0);
    drive(1, 1'b0, 1'b1, 24'h000020, 16'hBEEF, 2'b11);
    step();
    chk("first_cycle_no_grant", cap_seen, 1'b0);
    step();
    chk("contention_first_p0", cap_seen && cap_port == 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    chk("contention_m_read", m_if.read, 1'b1);
    chk("contention_m_addr_rd", m_if.address, 24'h000010);
    step();
    chk("contention_second_p1", cap_seen && cap_port == 1'b1, 1'b1);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    chk("contention_m_write", m_if.write, 1'b1);
    chk("contention_m_addr_wr", m_if.address, 24'h000020);
    chk("contention_m_wdata", m_if.writedata, 16'hBEEF);
    chk("contention_m_be", m_if.byteenable, 2'b11);
    step();
    drain_reads();

    // stall hold
    m_if.waitrequest = 1'b1;
    drive(0, 1'b1, 1'b0, 24'h000123, '0, '0);
    step();
    chk("stall_capture", cap_seen && cap_port == 1'b0, 1'b1);
    idle_ports();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, 1'b0, 24'h000777, '0, '0);
      step();
      chk("stall_m_address", m_if.address, 24'h000123);
      chk("stall_m_read", m_if.read, 1'b1);
    end
    idle_ports();
    m_if.waitrequest = 1'b0;
    step();
    drain_reads();

    // outstanding full
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1'b1, 1'b0, AW'(24'h000200 + acc), '0, '0);
      step();
      if (cap_seen) acc++;
    end
    chk("full_accepted_reads", acc, 8);
    drive(0, 1'b0, 1'b1, 24'h000300, 16'h5A5A, 2'b01);
    step();
    chk("full_write_accepted", cap_seen && cap_port == 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    m_if.readdatavalid = 1'b1; m_if.readdata = 16'h0BAD;
    step();
    chk("full_no_push_on_pop", cap_seen, 1'b0);
    m_if.readdatavalid = 1'b0;
    step();
    chk("full_ninth_accepted", cap_seen && cap_port == 1'b1, 1'b1);
    idle_ports();
    step();
    drain_reads();

    // routing p0,p1,p1,p0
    for (int i = 0; i < 4; i++) begin
      drive(route_port[i], 1'b1, 1'b0, AW'(24'h000400 + i), '0, '0);
      step();
      idle_ports();
    end
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back(route_data[i]);
    for (int i = 0; i < 4; i++) begin
      m_if.readdatavalid = 1'b1; m_if.readdata = route_data[i];
      #1;
      chk("route_p0_valid", p0_if.readdatavalid, route_port[i] == 0);
      chk("route_p1_valid", p1_if.readdatavalid, route_port[i] == 1);
      if (route_port[i] == 0) chk("route_p0_data", p0_if.readdata, exp_q.pop_front());
      else                    chk("route_p1_data", p1_if.readdata, exp_q.pop_front());
      step();
    end
    m_if.readdatavalid = 1'b0;
    step();

    // fairness
    grant_log.delete();
    guard = 0;
    while (grant_log.size() < 20 && guard < 100) begin
      drive(0, 1'b1, 1'b0, AW'($urandom), '0, '0);
      drive(1, 1'b1, 1'b0, AW'($urandom), '0, '0);
      m_if.readdatavalid = (idq.size() > 0);
      m_if.readdata = DW'($urandom);
      step();
      guard++;
    end
    idle_ports();
    m_if.readdatavalid = 1'b0;
    chk("fair_grant_count", grant_log.size(), 20);
    c0 = 0; c1 = 0; same = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (grant_log[i] == 0) c0++; else c1++;
      if (i > 0 && grant_log[i] == grant_log[i-1]) same++;
    end
    chk("fair_p0_grants", c0, 10);
    chk("fair_p1_grants", c1, 10);
    chk("fair_repeats", same, 0);
    step();
    drain_reads();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        int r;
        r = $urandom_range(0, 3);
        drive(p, r == 1, r == 2, AW'($urandom), DW'($urandom), 2'($urandom));
      end
      m_if.waitrequest = ($urandom_range(0, 3) == 0);
      m_if.readdatavalid = (idq.size() > 0) && ($urandom_range(0, 1) == 1);
      m_if.readdata = DW'($urandom);
      step();
    end
    idle_ports();
    m_if.readdatavalid = 1'b0;
    m_if.waitrequest = 1'b0;
    step();
    drain_reads();

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, AW'(24'h000500 + i), '0, '0);
      step();
      idle_ports();
    end
    m_if.waitrequest = 1'b1;
    drive(1, 1'b1, 1'b0, 24'h000600, '0, '0);
    step();
    idle_ports();
    chk("midop_cmd_held", m_if.read, 1'b1);
    rst_n = 1'b0;
    model_reset();
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_if.waitrequest = 1'b0;
    step();
    m_if.readdatavalid = 1'b1; m_if.readdata = 16'hDEAD;
    step();
    m_if.readdatavalid = 1'b0;
    step();
    chk("midop_err_sticky", dut.err_q, 1'b1);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SDRAM data width.
REQ-003 Parameter RD_DEPTH, default 8, max outstanding reads; power of two, at least 2.
REQ-004 clk_clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 pN_address  in  ADDR_W, with N=0 (instruction fetch) and N=1 (data).
REQ-007 pN_read, pN_write  in  1  each  requester commands; never both high.
REQ-008 pN_writedata  in  DATA_W; pN_byteenable  in  DATA_W/8.
REQ-009 pN_waitrequest  out  1  low means the command is accepted this cycle.
REQ-010 pN_readdata  out  DATA_W; pN_readdatavalid  out  1.
REQ-011 m_address  out  ADDR_W; m_read, m_write  out  1 each; m_writedata  out  DATA_W; m_byteenable  out  DATA_W/8.
REQ-012 m_waitrequest  in  1; m_readdata  in  DATA_W; m_readdatavalid  in  1; these face the SDRAM controller, which returns reads in order.

Function
REQ-013 One command register (cmd_valid, cmd_port, plus fields) drives the m_* outputs.
- m_read = cmd_valid and cmd is a read; m_write likewise for writes.
REQ-014 Drain: cmd_valid clears when m_waitrequest=0 while cmd_valid=1.
REQ-015 Capture is possible when cmd_valid=0 or drain occurs this cycle (zero-bubble back-to-back).
REQ-016 Eligibility: port N is eligible when pN_read or pN_write is high.
- A read is eligible only when rd_count < RD_DEPTH.
REQ-017 Grant is round-robin via last_port register.
- Both eligible: grant port != last_port.
- One eligible: grant it.
- last_port updates on each capture; reset value 1 (port 0 wins the first tie).
REQ-018 pN_waitrequest = 0 only in the cycle port N's command is captured; otherwise 1, including when idle.
REQ-019 A captured command appears on m_* in the next cycle, and is held stable until drained.
REQ-020 On capture of a read, push the port ID into the ID FIFO (depth RD_DEPTH).
- rd_count increments on push and decrements on m_readdatavalid.
- Push and pop in the same cycle leave rd_count unchanged.
REQ-021 On m_readdatavalid, route by FIFO head.
- pN_readdatavalid=1 for the head port only, in the same cycle (combinational).
- pN_readdata = m_readdata for both ports.
REQ-022 m_readdatavalid with an empty FIFO is discarded; a sticky error flag sets (internal, for assertions).
REQ-023 When rd_count = RD_DEPTH, reads stall with waitrequest=1 and writes remain grantable.
- The read-eligibility check uses the pre-pop rd_count, so there is no push-on-pop when full.
REQ-024 The FIFO pointers are log2(RD_DEPTH) bits and wrap modulo RD_DEPTH; rd_count is log2(RD_DEPTH)+1 bits.
REQ-025 Writes produce no response and no FIFO entry.

Reset
REQ-026 Asserting reset_reset_n low sets:
- cmd_valid=0, m_read=0, m_write=0;
- m_address, m_writedata, m_byteenable all 0;
- pN_waitrequest=1, pN_readdatavalid=0;
- FIFO empty, rd_count=0, last_port=1, error flag=0.
REQ-027 Reset mid-operation abandons the held command and outstanding reads; no responses are routed afterwards for them.
REQ-028 Reset release is synchronized externally; no grant occurs in the first cycle after deassertion.

Structure
REQ-029 Package sdram_arb_pkg holds:
- ADDR_W/DATA_W defaults;
- the port-ID typedef (1 bit);
- the command struct type (address, writedata, byteenable, is_write, port).
REQ-030 Sub-module sdram_arb_id_fifo: synchronous FIFO with push/pop/full/empty/count, with no read latency on the head.
REQ-031 The top module contains the grant logic, command register and response routing only.

Verification
REQ-032 Contention: p0_read@0x000010 and p1_write@0x000020 (data 0xBEEF, be 2'b11) in the same cycle after reset.
- p0 is granted first, then p1 in the next cycle.
- m_* shows the read, then the write.
REQ-033 Stall hold: m_waitrequest=1 for 5 cycles during a read.
- m_address and m_read stay constant.
- Both pN_waitrequest=1 throughout.
REQ-034 Outstanding full: with m_readdatavalid held low, issue 9 p1 reads.
- Exactly 8 are accepted and the 9th stalls.
- A p0 write is still accepted.
- One readdatavalid lets the 9th read be accepted on the following cycle.
REQ-035 Routing: interleaved reads in order p0, p1, p1, p0; return data 0x1111, 0x2222, 0x3333, 0x4444.
- pN_readdatavalid pulses in the matching order with the matching data.
- The other port stays low.
REQ-036 Fairness: both ports issue continuous reads for 20 accepted commands.
- Grants alternate strictly, 10 per port.
REQ-037 Reset mid-op: assert reset with 3 reads outstanding and cmd_valid=1.
- All outputs take their REQ-026 values.
- A later stray m_readdatavalid sets the error flag and produces no pN_readdatavalid.
